// File: rtl/four_bank_mem_responder_if.sv
// ---------------------------------------------------------------------------
// four_bank_mem_responder_if
// Request/response bundle between the cache controller (master) and the
// four-bank main-memory responder (slave).
//   addr     master->slave  16  byte address (bank = addr[2:1])
//   data_in  master->slave  16  write data
//   wr, rd   master->slave   1  write / read request (both high = illegal)
//   data_out slave->master  16  read return, one-cycle pulse, 0 otherwise
//   stall    slave->master   1  request present but target bank busy
//   busy     slave->master   4  per-bank busy flags
//   err      slave->master   1  illegal request this cycle
// ---------------------------------------------------------------------------
interface four_bank_mem_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, stall, busy, err
    );
endinterface

// File: rtl/four_bank_mem_responder.sv
// ---------------------------------------------------------------------------
// four_bank_mem_responder
// Four-bank interleaved 16-bit word memory answering the cache controller's
// writeback/fill traffic. One request per cycle; a request to a busy bank is
// stalled; read data returns READ_LAT cycles after the accept edge as a
// one-cycle pulse on data_out.
//
// Ports
//   clk  in   clock, all state on the rising edge
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of four_bank_mem_responder_if (addr/data_in/wr/rd in,
//        data_out/stall/busy/err out)
//
// Parameters
//   ROW_BITS     rows per bank = 2**ROW_BITS, row = addr[ROW_BITS+2:3]
//   BUSY_CYCLES  cycles a bank stays busy after an accept (2..7)
//   READ_LAT     accept edge to data_out pulse, in cycles (1..BUSY_CYCLES)
//
// Build option
//   MEM_ALIGN_CHECK_EN  when defined, an odd byte address raises err and the
//                       request is dropped; otherwise addr[0] is ignored.
// ---------------------------------------------------------------------------
module four_bank_mem_responder #(
    parameter int ROW_BITS    = 8,
    parameter int BUSY_CYCLES = 4,
    parameter int READ_LAT    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    four_bank_mem_responder_if.slave    bus
);
    localparam int ROWS = 2 ** ROW_BITS;

    logic [1:0]          w_bank;
    logic [ROW_BITS-1:0] w_row;
    logic                w_req;
    logic                w_err;
    logic                w_stall;
    logic                w_acc;
    logic                w_rd_acc;
    logic                w_unused;

    logic [2:0]          r_cnt  [4];
    logic [3:0]          r_busy;
    logic [15:0]         r_mem  [4][ROWS];
    logic [READ_LAT:1]   r_vld_pipe;
    logic [15:0]         r_dat_pipe [1:READ_LAT];

    assign w_bank = bus.addr[2:1];
    assign w_row  = bus.addr[ROW_BITS+2:3];
    assign w_req  = bus.rd ^ bus.wr;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_err    = (bus.rd & bus.wr) | (w_req & bus.addr[0]);
    assign w_unused = &{1'b0, bus.addr[15:ROW_BITS+3]};
`else
    // Odd byte addresses simply hit the containing word.
    assign w_err    = bus.rd & bus.wr;
    assign w_unused = &{1'b0, bus.addr[0], bus.addr[15:ROW_BITS+3]};
`endif

    assign w_stall  = w_req & r_busy[w_bank];
    assign w_acc    = w_req & ~w_stall & ~w_err;
    assign w_rd_acc = w_acc & bus.rd;

    assign bus.stall    = w_stall;
    assign bus.err      = w_err;
    assign bus.busy     = r_busy;
    assign bus.data_out = r_dat_pipe[READ_LAT];

    // Per-bank occupancy counters. busy is kept as its own flop so the flag
    // leaves the block registered rather than as a decode of the count.
    // An accept only happens on an idle bank, so load and countdown never
    // collide within one bank.
    for (genvar b = 0; b < 4; b++) begin : g_bank
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt[b]  <= '0;
                r_busy[b] <= 1'b0;
            end else if (w_acc && (w_bank == 2'(b))) begin
                r_cnt[b]  <= 3'(BUSY_CYCLES);
                r_busy[b] <= 1'b1;
            end else if (r_cnt[b] != 3'd0) begin
                r_cnt[b]  <= r_cnt[b] - 3'd1;
                r_busy[b] <= (r_cnt[b] != 3'd1);
            end
        end
    end

    // Word array, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++)
                for (int r = 0; r < ROWS; r++)
                    r_mem[b][r] <= '0;
        end else if (w_acc && bus.wr) begin
            r_mem[w_bank][w_row] <= bus.data_in;
        end
    end

    // Read return pipe. Data is zeroed when not valid so the last stage can
    // drive data_out directly and the idle value is 0 without a mux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe <= '0;
            for (int s = 1; s <= READ_LAT; s++)
                r_dat_pipe[s] <= '0;
        end else begin
            r_vld_pipe[1] <= w_rd_acc;
            r_dat_pipe[1] <= w_rd_acc ? r_mem[w_bank][w_row] : 16'h0000;
            for (int s = 2; s <= READ_LAT; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_dat_pipe[s] <= r_dat_pipe[s-1];
            end
        end
    end
endmodule

// File: tb/tb_four_bank_mem_responder.sv
module tb_four_bank_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    four_bank_mem_responder_if bus_if ();

    four_bank_mem_responder #(
        .ROW_BITS   (8),
        .BUSY_CYCLES(4),
        .READ_LAT   (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        bus_if.rd      = r;
        bus_if.wr      = w;
        bus_if.addr    = a;
        bus_if.data_in = d;
        #1;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        bus_if.rd = 1'b0; bus_if.wr = 1'b0;
        bus_if.addr = 16'h0000; bus_if.data_in = 16'h0000;
        #2;
        chk("rst_data_out", bus_if.data_out, 16'h0000);
        chk("rst_busy", 16'(bus_if.busy), 16'h0000);
        chk("rst_stall", 16'(bus_if.stall), 16'h0000);
        chk("rst_err", 16'(bus_if.err), 16'h0000);
        #10 rst = 1'b0;

        // write BEEF, wait out the bank, read it back
        tick(); drv(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        chk("t1_wr_stall", 16'(bus_if.stall), 16'h0000);
        chk("t1_wr_err", 16'(bus_if.err), 16'h0000);
        for (int k = 0; k < 4; k++) begin
            tick(); idle();
            chk("t1_busy_hi", 16'(bus_if.busy), 16'h0001);
        end
        tick(); drv(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("t1_busy_lo", 16'(bus_if.busy), 16'h0000);
        chk("t1_rd_stall", 16'(bus_if.stall), 16'h0000);
        tick(); idle();
        chk("t1_lat1", bus_if.data_out, 16'h0000);
        tick();
        chk("t1_lat2", bus_if.data_out, 16'hBEEF);
        tick();
        chk("t1_lat3", bus_if.data_out, 16'h0000);
        repeat (3) tick();

        // bank conflict on bank 1
        tick(); drv(1'b0, 1'b1, 16'h0002, 16'h1234);
        chk("t2_wr_stall", 16'(bus_if.stall), 16'h0000);
        tick(); drv(1'b1, 1'b0, 16'h000A, 16'h0000);
        for (int k = 0; k < 4; k++) begin
            chk("t2_stall_hi", 16'(bus_if.stall), 16'h0001);
            chk("t2_busy_b1", 16'(bus_if.busy), 16'h0002);
            tick();
        end
        #1;
        chk("t2_stall_lo", 16'(bus_if.stall), 16'h0000);
        chk("t2_busy_lo", 16'(bus_if.busy), 16'h0000);
        tick(); idle();
        chk("t2_rd_busy", 16'(bus_if.busy), 16'h0002);
        tick();
        chk("t2_rd_data", bus_if.data_out, 16'h0000);
        repeat (3) tick();

        // fill the other banks, then four back-to-back reads
        tick(); drv(1'b0, 1'b1, 16'h0000, 16'hA000);
        tick(); drv(1'b0, 1'b1, 16'h0004, 16'hC000);
        chk("t3_wr_bank2_stall", 16'(bus_if.stall), 16'h0000);
        tick(); drv(1'b0, 1'b1, 16'h0006, 16'hD000);
        tick(); idle();
        repeat (4) tick();
        drv(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("t3_stall0", 16'(bus_if.stall), 16'h0000);
        tick(); drv(1'b1, 1'b0, 16'h0002, 16'h0000);
        chk("t3_stall1", 16'(bus_if.stall), 16'h0000);
        tick(); drv(1'b1, 1'b0, 16'h0004, 16'h0000);
        chk("t3_stall2", 16'(bus_if.stall), 16'h0000);
        chk("t3_ret0", bus_if.data_out, 16'hA000);
        tick(); drv(1'b1, 1'b0, 16'h0006, 16'h0000);
        chk("t3_stall3", 16'(bus_if.stall), 16'h0000);
        chk("t3_ret1", bus_if.data_out, 16'h1234);
        tick(); idle();
        chk("t3_busy_all", 16'(bus_if.busy), 16'h000F);
        chk("t3_ret2", bus_if.data_out, 16'hC000);
        tick();
        chk("t3_ret3", bus_if.data_out, 16'hD000);
        tick();
        chk("t3_ret_end", bus_if.data_out, 16'h0000);
        repeat (4) tick();

        // rd & wr together is illegal and ignored
        tick(); drv(1'b1, 1'b1, 16'h0004, 16'hFFFF);
        chk("t4_err", 16'(bus_if.err), 16'h0001);
        chk("t4_stall", 16'(bus_if.stall), 16'h0000);
        tick(); idle();
        chk("t4_busy", 16'(bus_if.busy), 16'h0000);
        chk("t4_err_lo", 16'(bus_if.err), 16'h0000);
        tick();
        chk("t4_no_ret1", bus_if.data_out, 16'h0000);
        tick();
        chk("t4_no_ret2", bus_if.data_out, 16'h0000);
        tick(); drv(1'b1, 1'b0, 16'h0004, 16'h0000);
        tick(); idle();
        tick();
        chk("t4_array_kept", bus_if.data_out, 16'hC000);
        repeat (4) tick();

        // odd byte address
        tick(); drv(1'b0, 1'b1, 16'h0003, 16'h5678);
`ifdef MEM_ALIGN_CHECK_EN
        chk("t6_err", 16'(bus_if.err), 16'h0001);
        tick(); idle();
        chk("t6_busy", 16'(bus_if.busy), 16'h0000);
`else
        chk("t6_err", 16'(bus_if.err), 16'h0000);
        tick(); idle();
        chk("t6_busy", 16'(bus_if.busy), 16'h0002);
`endif
        repeat (4) tick();
        drv(1'b1, 1'b0, 16'h0002, 16'h0000);
        tick(); idle();
        tick();
`ifdef MEM_ALIGN_CHECK_EN
        chk("t6_word", bus_if.data_out, 16'h1234);
`else
        chk("t6_word", bus_if.data_out, 16'h5678);
`endif
        repeat (4) tick();

        // reset with a read in flight
        tick(); drv(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("t5_rd_stall", 16'(bus_if.stall), 16'h0000);
        tick(); idle();
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_data", bus_if.data_out, 16'h0000);
        chk("t5_rst_busy", 16'(bus_if.busy), 16'h0000);
        #3 rst = 1'b0;
        tick();
        chk("t5_drop1", bus_if.data_out, 16'h0000);
        tick();
        chk("t5_drop2", bus_if.data_out, 16'h0000);
        drv(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("t5_busy_clear", 16'(bus_if.busy), 16'h0000);
        tick(); drv(1'b1, 1'b0, 16'h0004, 16'h0000);
        tick(); idle();
        chk("t5_zero_0010", bus_if.data_out, 16'h0000);
        tick();
        chk("t5_zero_0004", bus_if.data_out, 16'h0000);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
